// File: rtl/mul_pkg.sv
// Shared constants and FSM encoding for the arbitrated shift-add multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mul_pkg;

    localparam int OP_W      = 8;
    localparam int MUL_STEPS = 8;
    localparam int STEP_W    = $clog2(MUL_STEPS);
    localparam int PROD_W    = 2 * OP_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mul_core.sv
// Sequential shift-add multiplier: one partial product per cycle over latched operands.
// Latency: done pulses MUL_STEPS cycles after the start cycle; y holds until the next done.
// Backpressure: none; start is honoured whenever asserted and restarts the datapath.
module mul_core
    import mul_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              last,
    output logic              done,
    output logic [PROD_W-1:0] y
);

    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [STEP_W-1:0] step_q;
    logic [PROD_W-1:0] acc_q;
    logic              running_q;
    logic [PROD_W-1:0] partial;
    logic [PROD_W-1:0] acc_nxt;

    // Partial product for the current bit of B, weighted by its position.
    always_comb begin
        partial = {{OP_W{1'b0}}, a_q & {OP_W{b_q[step_q]}}} << step_q;
        acc_nxt = acc_q + partial;
        last    = running_q && (step_q == STEP_W'(MUL_STEPS - 1));
    end

    // Operand latch, step counter and accumulator; final step publishes the result.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            step_q    <= '0;
            acc_q     <= '0;
            running_q <= 1'b0;
            done      <= 1'b0;
            y         <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q       <= a;
                b_q       <= b;
                step_q    <= '0;
                acc_q     <= '0;
                running_q <= 1'b1;
            end else if (running_q) begin
                acc_q  <= acc_nxt;
                step_q <= step_q + 1'b1;
                if (last) begin
                    running_q <= 1'b0;
                    y         <= acc_nxt;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one 8x8 shift-add multiplier among N_REQ requesters.
// Latency: gnt 1 cycle after request seen in IDLE, done 8 cycles after gnt, 1 op per 9 cycles.
// Backpressure: requests are level-held; losers and requests during RUN simply wait.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [OP_W*N_REQ-1:0]   a_bi,
    input  logic [OP_W*N_REQ-1:0]   b_bi,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        done_o,
    output logic [PROD_W-1:0]       y_bo,
    output logic [2:0]              owner_o,
    output logic                    busy_o
);

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        last_winner_q;
    logic [2:0]        winner;
    logic              any_req;
    logic              start;
    logic              core_last;
    logic              core_done;
    logic [PROD_W-1:0] core_y;

    // Round-robin pick: scan from last_winner+1 and keep the closest active request.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            int idx;
            idx = (int'(last_winner_q) + i) % N_REQ;
            if (req_i[idx]) begin
                any_req = 1'b1;
                winner  = 3'(idx);
            end
        end
    end

    // Next-state logic: grant from IDLE, fall back to IDLE on the core's final step.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    start   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, grant pulse and ownership registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            gnt_o         <= '0;
            owner_o       <= '0;
            last_winner_q <= 3'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_o   <= '0;
            if (start) begin
                gnt_o         <= N_REQ'(1) << winner;
                owner_o       <= winner;
                last_winner_q <= winner;
            end
        end
    end

    // Result-valid pulse is steered to the requester that owns the operation.
    always_comb begin
        done_o = core_done ? (N_REQ'(1) << owner_o) : '0;
        busy_o = (state_q == ST_RUN);
        y_bo   = core_y;
    end

    mul_core u_core (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (start),
        .a     (a_bi[winner*OP_W +: OP_W]),
        .b     (b_bi[winner*OP_W +: OP_W]),
        .last  (core_last),
        .done  (core_done),
        .y     (core_y)
    );

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul_arbiter;

    localparam int N = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_i;
    logic [8*N-1:0] a_bi;
    logic [8*N-1:0] b_bi;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   done_o;
    logic [15:0]    y_bo;
    logic [2:0]     owner_o;
    logic           busy_o;

    always #5 clk_i = ~clk_i;

    mul_arbiter #(.N_REQ(N)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .gnt_o   (gnt_o),
        .done_o  (done_o),
        .y_bo    (y_bo),
        .owner_o (owner_o),
        .busy_o  (busy_o)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: cycles remaining in the current op, owner, result.
    int          m_rem   = 0;
    int          m_owner = 0;
    int          m_lw    = N - 1;
    logic [15:0] m_y     = '0;
    logic [15:0] m_prod  = '0;
    logic [N-1:0] m_gnt  = '0;
    logic [N-1:0] m_done = '0;
    int          gnt_log[$];
    int          done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        m_gnt  = '0;
        m_done = '0;
        if (!rst_i) begin
            m_rem   = 0;
            m_y     = '0;
            m_owner = 0;
            m_lw    = N - 1;
        end else if (m_rem == 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                int av;
                int bv;
                c = (m_lw + k) % N;
                if (req_i[c]) begin
                    av       = int'(a_bi[c*8 +: 8]);
                    bv       = int'(b_bi[c*8 +: 8]);
                    m_prod   = 16'(av * bv);
                    m_owner  = c;
                    m_lw     = c;
                    m_gnt[c] = 1'b1;
                    m_rem    = 8;
                    gnt_log.push_back(c);
                    break;
                end
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_done[m_owner] = 1'b1;
                m_y             = m_prod;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
        if (done_o != 0) done_cnt++;
        check("gnt",   32'(gnt_o),   32'(m_gnt));
        check("done",  32'(done_o),  32'(m_done));
        check("busy",  32'(busy_o),  32'(m_rem != 0));
        check("owner", 32'(owner_o), 32'(m_owner));
        check("y",     32'(y_bo),    32'(m_y));
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        req_i = '0;
        tick();
        tick();
        rst_i = 1'b1;
        gnt_log.delete();
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done_o == 0 && n < budget);
        check("done_seen", 32'(done_o != 0), 32'd1);
    endtask

    initial begin
        int n;
        int exp_order[5];
        rst_i = 1'b0;
        req_i = '0;
        a_bi  = '0;
        b_bi  = '0;

        // Reset state
        do_reset();
        check("rst_y",     32'(y_bo),    32'd0);
        check("rst_busy",  32'(busy_o),  32'd0);
        check("rst_owner", 32'(owner_o), 32'd0);

        // Single request 13*11
        a_bi[7:0] = 8'd13;
        b_bi[7:0] = 8'd11;
        req_i     = 4'b0001;
        tick();
        check("single_gnt", 32'(gnt_o), 32'h1);
        req_i = '0;
        wait_done(20, n);
        check("single_lat",  32'(n),      32'd8);
        check("single_done", 32'(done_o), 32'h1);
        check("single_y",    32'(y_bo),   32'd143);

        // All requesters at once, held
        do_reset();
        for (int k = 0; k < N; k++) begin
            a_bi[k*8 +: 8] = 8'($urandom);
            b_bi[k*8 +: 8] = 8'($urandom);
        end
        req_i = 4'b1111;
        for (int c = 0; c < 45; c++) tick();
        req_i = '0;
        exp_order = '{0, 1, 2, 3, 0};
        check("all_cnt", 32'(gnt_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++)
            check("all_order", 32'(gnt_log[k]), 32'(exp_order[k]));

        // Boundary operands
        do_reset();
        a_bi[7:0] = 8'd255;
        b_bi[7:0] = 8'd255;
        req_i     = 4'b0001;
        tick();
        req_i = '0;
        wait_done(20, n);
        check("max_y", 32'(y_bo), 32'hFE01);
        a_bi[15:8] = 8'd0;
        b_bi[15:8] = 8'd200;
        req_i      = 4'b0010;
        tick();
        req_i = '0;
        wait_done(20, n);
        check("zero_y", 32'(y_bo), 32'd0);

        // Operand change during RUN
        do_reset();
        a_bi[7:0] = 8'd7;
        b_bi[7:0] = 8'd9;
        req_i     = 4'b0001;
        tick();
        req_i     = '0;
        a_bi[7:0] = 8'd100;
        wait_done(20, n);
        check("latch_y", 32'(y_bo), 32'd63);

        // Reset in the middle of an operation
        do_reset();
        a_bi[15:8] = 8'd50;
        b_bi[15:8] = 8'd3;
        req_i      = 4'b0010;
        tick();
        req_i = '0;
        for (int c = 0; c < 4; c++) tick();
        rst_i = 1'b0;
        tick();
        rst_i    = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) tick();
        check("abort_done", 32'(done_cnt), 32'd0);
        check("abort_y",    32'(y_bo),     32'd0);
        req_i = 4'b0011;
        tick();
        check("abort_next", 32'(gnt_o), 32'h1);
        req_i = '0;
        for (int c = 0; c < 9; c++) tick();

        // Fairness: requester 1 held, requester 2 joins during RUN
        do_reset();
        req_i = 4'b0010;
        tick();
        tick();
        tick();
        req_i = 4'b0110;
        for (int c = 0; c < 25; c++) tick();
        req_i = '0;
        check("fair_cnt", 32'(gnt_log.size() >= 3), 32'd1);
        exp_order[0] = 1;
        exp_order[1] = 2;
        exp_order[2] = 1;
        for (int k = 0; k < 3 && k < gnt_log.size(); k++)
            check("fair_order", 32'(gnt_log[k]), 32'(exp_order[k]));

        // Randomized traffic with occasional resets and boundary operands
        do_reset();
        for (int c = 0; c < 800; c++) begin
            req_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
            a_bi  = 32'($urandom);
            b_bi  = 32'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                a_bi = '1;
                b_bi = '1;
            end
            rst_i = ($urandom_range(0, 149) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
